// File: rtl/video_pkg.sv
// Shared video types and defaults for the framebuffer reader.
package video_pkg;

  localparam int unsigned HDISP_DEFAULT   = 800;
  localparam int unsigned VDISP_DEFAULT   = 480;
  localparam int unsigned BYTES_PER_PIXEL = 4;

  // One framebuffer word: {pad, R, G, B}
  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {IDLE, FETCH} fb_state_e;

  // Buffered stream entry; width 34
  typedef struct packed {
    logic   sof;
    logic   eol;
    pixel_t data;
  } fb_entry_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry comes straight from storage flops.
module fb_sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok;

  assign pop_ok = pop & ~empty;
  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign count  = count_q;
  assign rdata  = mem_q[rd_ptr_q];

  // Occupancy update; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    unique case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fb_reader.sv
// Avalon-MM read master scanning the framebuffer in raster order into a pixel stream.
module fb_reader
  import video_pkg::*;
#(
  parameter int unsigned HDISP      = HDISP_DEFAULT,
  parameter int unsigned VDISP      = VDISP_DEFAULT,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_sof,
  output logic        px_eol,
  output logic        frame_done
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fb_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0] addr_q, addr_d;
  logic        hold_q;
  logic        frame_done_q;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fb_entry_t     push_entry, head;

  logic room, done, x_last, y_last, frame_last;

  // Room for the word this request will return
  assign room       = (fifo_count < CW'(FIFO_DEPTH));
  // A stalled request is held regardless of FIFO state
  assign avm_read   = (state_q == FETCH) & (hold_q | room);
  assign done       = avm_read & ~avm_waitrequest;
  assign x_last     = (x_q == XW'(HDISP - 1));
  assign y_last     = (y_q == YW'(VDISP - 1));
  assign frame_last = x_last & y_last;

  // Raster order is contiguous, so the address tracks BASE_ADDR + 4*(y*HDISP + x) by increment
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;

  assign push_entry.sof  = (x_q == '0) && (y_q == '0);
  assign push_entry.eol  = x_last;
  assign push_entry.data = avm_readdata;
  assign fifo_push       = done;
  assign fifo_pop        = px_valid & px_ready;

  assign px_valid   = ~fifo_empty;
  assign px_data    = head.data;
  assign px_sof     = head.sof & ~fifo_empty;
  assign px_eol     = head.eol & ~fifo_empty;
  assign frame_done = frame_done_q;

  // Next state, raster counters and address
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (done && frame_last && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (done) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      addr_d = frame_last ? BASE_ADDR : addr_q + 32'(BYTES_PER_PIXEL);
    end
  end

  // State, counters, request hold flag and frame pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= BASE_ADDR;
      hold_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      hold_q       <= avm_read & avm_waitrequest;
      frame_done_q <= done & frame_last;
    end
  end

  fb_sync_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fb_reader.sv
// Directed and randomised bench for fb_reader with a small framebuffer.
module tb_fb_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        px_sof;
  logic        px_eol;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_cnt   = 0;
  int ovf_cnt  = 0;
  logic [31:0] q_rd[$];
  logic [33:0] q_px[$];

  always #5 sys_clk = ~sys_clk;

  // Slave returns its own address as data
  assign avm_readdata = avm_address;

  fb_reader #(
    .HDISP      (4),
    .VDISP      (2),
    .BASE_ADDR  (32'h100),
    .FIFO_DEPTH (4)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .enable          (enable),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .px_data         (px_data),
    .px_valid        (px_valid),
    .px_ready        (px_ready),
    .px_sof          (px_sof),
    .px_eol          (px_eol),
    .frame_done      (frame_done)
  );

  // Bus/stream monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (avm_read && !avm_waitrequest) q_rd.push_back(avm_address);
      if (px_valid && px_ready) q_px.push_back({px_sof, px_eol, px_data});
      if (frame_done) fd_cnt++;
      if (dut.fifo_push && dut.fifo_full) ovf_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected i-th pixel of the stream: {sof, eol, data}
  function automatic logic [33:0] exp_px(input int i);
    logic [31:0] a;
    a = 32'h100 + 32'(4 * (i % 8));
    return {(i % 8) == 0, (i % 4) == 3, a};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 2000 && q_rd.size() < n; i++) step(1);
    if (q_rd.size() < n) check("wait_reads_timeout", 64'(q_rd.size()), 64'(n));
  endtask

  task automatic wait_px(input int n);
    for (int i = 0; i < 2000 && q_px.size() < n; i++) step(1);
    if (q_px.size() < n) check("wait_px_timeout", 64'(q_px.size()), 64'(n));
  endtask

  task automatic clear_logs();
    q_rd.delete();
    q_px.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    sys_rst_n       = 1'b0;
    enable          = 1'b0;
    px_ready        = 1'b1;
    avm_waitrequest = 1'b0;
    step(3);
    sys_rst_n = 1'b1;
    clear_logs();
  endtask

  // Compares both logs to the ideal raster stream; returns number of bad entries
  function automatic int seq_errors(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= q_rd.size() || q_rd[i] !== 32'h100 + 32'(4 * (i % 8))) e++;
      if (i >= q_px.size() || q_px[i] !== exp_px(i)) e++;
    end
    return e;
  endfunction

  initial begin
    int  cnt;
    bit  found;

    // Reset state
    sys_rst_n       = 1'b0;
    enable          = 1'b0;
    px_ready        = 1'b1;
    avm_waitrequest = 1'b0;
    #12;
    check("rst_read",   64'(avm_read),       64'd0);
    check("rst_addr",   64'(avm_address),    64'h100);
    check("rst_valid",  64'(px_valid),       64'd0);
    check("rst_sof",    64'(px_sof),         64'd0);
    check("rst_eol",    64'(px_eol),         64'd0);
    check("rst_fdone",  64'(frame_done),     64'd0);
    check("rst_be",     64'(avm_byteenable), 64'hF);
    step(2);
    sys_rst_n = 1'b1;
    clear_logs();

    // Free-running stream; enable dropped in frame 2, frame completes then idles
    enable = 1'b1;
    wait_reads(10);
    enable = 1'b0;
    step(20);
    check("t1_nreads", 64'(q_rd.size()), 64'd16);
    check("t1_npx",    64'(q_px.size()), 64'd16);
    check("t1_fdone",  64'(fd_cnt),      64'd2);
    check("t1_idle",   64'(avm_read),    64'd0);
    for (int i = 0; i < 16 && i < q_rd.size() && i < q_px.size(); i++) begin
      check($sformatf("t1_addr%0d", i), 64'(q_rd[i]), 64'(32'h100 + 32'(4 * (i % 8))));
      check($sformatf("t1_px%0d", i),   64'(q_px[i]), 64'(exp_px(i)));
    end
    // Re-enable starts at pixel (0,0)
    clear_logs();
    enable = 1'b1;
    wait_reads(1);
    if (q_rd.size() > 0) check("t1_reenable_addr", 64'(q_rd[0]), 64'h100);

    // Waitrequest stall on 0x108
    do_reset();
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1);
      if (avm_read && avm_address == 32'h108) found = 1'b1;
    end
    check("t2_found", 64'(found), 64'd1);
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_hold_read%0d", k), 64'(avm_read),    64'd1);
      check($sformatf("t2_hold_addr%0d", k), 64'(avm_address), 64'h108);
      step(1);
    end
    avm_waitrequest = 1'b0;
    enable = 1'b0;
    step(20);
    cnt = 0;
    foreach (q_px[i]) if (q_px[i][31:0] == 32'h108) cnt++;
    check("t2_one_push_108", 64'(cnt), 64'd1);
    check("t2_npx", 64'(q_px.size()), 64'd8);
    check("t2_seq", 64'(seq_errors(8)), 64'd0);

    // Backpressure: FIFO fills, reads stop, head stays put
    do_reset();
    px_ready = 1'b0;
    enable   = 1'b1;
    step(30);
    check("t3_nreads", 64'(q_rd.size()), 64'd4);
    check("t3_read0",  64'(avm_read),    64'd0);
    check("t3_valid",  64'(px_valid),    64'd1);
    check("t3_data",   64'(px_data),     64'h100);
    check("t3_sof",    64'(px_sof),      64'd1);
    step(5);
    check("t3_data_stable", 64'(px_data), 64'h100);
    px_ready = 1'b1;
    enable   = 1'b0;
    wait_px(8);
    step(5);
    check("t3_npx",    64'(q_px.size()), 64'd8);
    check("t3_nreads_all", 64'(q_rd.size()), 64'd8);
    check("t3_seq",    64'(seq_errors(8)), 64'd0);

    // Asynchronous reset during a stalled request with pixels buffered
    do_reset();
    px_ready = 1'b0;
    enable   = 1'b1;
    wait_reads(2);
    avm_waitrequest = 1'b1;
    step(1);
    check("t4_pre_read",  64'(avm_read), 64'd1);
    check("t4_pre_valid", 64'(px_valid), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("t4_rst_read",  64'(avm_read), 64'd0);
    check("t4_rst_valid", 64'(px_valid), 64'd0);
    step(2);
    avm_waitrequest = 1'b0;
    px_ready        = 1'b1;
    sys_rst_n       = 1'b1;
    clear_logs();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (avm_read) found = 1'b1;
    end
    check("t4_restart",      64'(found),       64'd1);
    check("t4_first_addr",   64'(avm_address), 64'h100);
    check("t4_not_yet_valid", 64'(px_valid),   64'd0);
    step(1);
    check("t4_lat_valid", 64'(px_valid), 64'd1);
    check("t4_lat_data",  64'(px_data),  64'h100);
    check("t4_lat_sof",   64'(px_sof),   64'd1);

    // Random backpressure and stalls over 20 frames
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 6000 && q_rd.size() < 160; c++) begin
      px_ready        = 1'($urandom_range(0, 1));
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      if (q_rd.size() >= 154) enable = 1'b0;
      step(1);
    end
    px_ready        = 1'b1;
    avm_waitrequest = 1'b0;
    wait_px(160);
    step(10);
    check("t5_nreads", 64'(q_rd.size()), 64'd160);
    check("t5_npx",    64'(q_px.size()), 64'd160);
    check("t5_seq",    64'(seq_errors(160)), 64'd0);
    check("t5_fdone",  64'(fd_cnt),      64'd20);
    check("t5_idle",   64'(avm_read),    64'd0);
    check("no_full_push", 64'(ovf_cnt),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
